// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared font table and digit constants for the seven-segment display block
package seg7_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIG_W      = $clog2(NUM_DIGITS);

  localparam logic [6:0] BLANK = 7'h00;

  // Active-high {g,f,e,d,c,b,a}; entry [0] is the glyph for 0, entry [15] for F.
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_count_display_if.sv
// rtl/seg7_count_display_if.sv - counter input, clear pulse and display pins of the count display
interface seg7_count_display_if;

  logic [3:0] count_in;
  logic       clear_wraps;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic [7:0] wrap_bcd;

  modport master (
    output count_in, clear_wraps,
    input  seg, dp, an, wrap_bcd
  );

  modport slave (
    input  count_in, clear_wraps,
    output seg, dp, an, wrap_bcd
  );

endinterface

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational nibble to active-high seven-segment glyph with blanking
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? BLANK : HEX_FONT[hex];

endmodule

// File: rtl/seg7_count_display.sv
// rtl/seg7_count_display.sv - samples the lab counter, counts F->0 wraps in BCD and scans a 4-digit display
module seg7_count_display
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  seg7_count_display_if.slave bus
);

  localparam int                  PS_W    = $clog2(SCAN_DIV);
  localparam logic [PS_W-1:0]     PS_LAST = PS_W'(SCAN_DIV - 1);
  localparam logic [6:0]          SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

  logic [3:0]            s1, s2, s3, accepted;
  logic [3:0]            tens, ones;
  logic [PS_W-1:0]       prescaler;
  logic [DIG_W-1:0]      dig_idx;
  logic                  scan_on;
  logic [6:0]            seg_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  take, wrap_hit, tick;
  logic [3:0]            dig_val;
  logic                  dig_blank;
  logic [6:0]            glyph;
  logic [NUM_DIGITS-1:0] dig_sel;

  // Only a value seen identically on two consecutive samples is accepted, so skewed bits never land.
  assign take     = (s2 == s3);
  assign wrap_hit = take && (accepted == 4'hF) && (s2 == 4'h0);
  assign tick     = (prescaler == PS_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      accepted <= '0;
    end else begin
      s1 <= bus.count_in;
      s2 <= s1;
      s3 <= s2;
      if (take) accepted <= s2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tens <= '0;
      ones <= '0;
    end else if (bus.clear_wraps) begin
      tens <= '0;
      ones <= '0;
    end else if (wrap_hit) begin
      if (ones == 4'd9) begin
        ones <= '0;
        tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

  // The first tick only arms the scan; digit 0 then gets a full slot before advancing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler <= '0;
      dig_idx   <= '0;
      scan_on   <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) begin
        if (!scan_on) scan_on <= 1'b1;
        else          dig_idx <= dig_idx + 1'b1;
      end
    end
  end

  always_comb begin
    dig_val   = 4'h0;
    dig_blank = 1'b1;
    case (dig_idx)
      DIG_W'(0): begin dig_val = accepted; dig_blank = 1'b0;            end
      DIG_W'(2): begin dig_val = ones;     dig_blank = 1'b0;            end
      DIG_W'(3): begin dig_val = tens;     dig_blank = (tens == 4'h0);  end
      default:   begin dig_val = 4'h0;     dig_blank = 1'b1;            end
    endcase
  end

  hex_to_seg7 u_font (
    .hex   (dig_val),
    .blank (dig_blank),
    .seg   (glyph)
  );

  assign dig_sel = NUM_DIGITS'(1) << dig_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
    end else if (scan_on) begin
      seg_q <= SEG_ACTIVE_LOW ? ~glyph : glyph;
      an_q  <= AN_ACTIVE_LOW ? ~dig_sel : dig_sel;
    end
  end

  assign bus.seg      = seg_q;
  assign bus.an       = an_q;
  assign bus.dp       = SEG_ACTIVE_LOW;
  assign bus.wrap_bcd = {tens, ones};

endmodule

// File: tb/tb_seg7_count_display.sv
// tb/tb_seg7_count_display.sv - scoreboard bench for seg7_count_display with a 4-cycle digit slot
module tb_seg7_count_display;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } disp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seg7_count_display_if bus();

  seg7_count_display #(
    .SCAN_DIV       (4),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  disp_t      disp_q[$];
  logic [7:0] wrap_q[$];

  // Cycles since reset release; digit slot k is lit for cyc in 5+4k .. 8+4k (index k mod 4).
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  function automatic logic [6:0] font(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic disp_t mk(input logic [3:0] an, input logic [6:0] seg);
    disp_t d;
    d.an  = an;
    d.seg = seg;
    return d;
  endfunction

  function automatic int next_window(input int min_c);
    int w = 5;
    while (w < min_c) w += 16;
    return w;
  endfunction

  task automatic wait_cyc(input int t);
    int guard = 0;
    while (cyc < t && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != t) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc: reached cyc %0d, want %0d", cyc, t);
    end
  endtask

  task automatic step_wrap;
    for (int v = 1; v < 16; v++) begin
      bus.count_in = 4'(v);
      repeat (4) @(negedge clk);
    end
    bus.count_in = 4'h0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset;
    disp_t e;
    rst = 1'b0;
    bus.count_in = 4'h0;
    bus.clear_wraps = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.dp !== 1'b1 || bus.wrap_bcd !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: an=%h seg=%h dp=%b wrap=%h, want an=f seg=7f dp=1 wrap=00",
               bus.an, bus.seg, bus.dp, bus.wrap_bcd);
    end
    rst = 1'b1;
    for (int k = 1; k <= 4; k++) disp_q.push_back(mk(4'hF, 7'h7F));
    disp_q.push_back(mk(4'b1110, ~font(4'h0)));
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      e = disp_q.pop_front();
      checks++;
      if (bus.an !== e.an || bus.seg !== e.seg) begin
        errors++;
        $display("FAIL first_scan cyc %0d: an=%b seg=%h, want an=%b seg=%h", cyc, bus.an, bus.seg, e.an, e.seg);
      end
    end
  endtask

  task automatic test_capture;
    disp_t e;
    int w = next_window(cyc + 4);
    wait_cyc(w - 3);
    bus.count_in = 4'h5;
    disp_q.push_back(mk(4'b1110, ~font(4'h0)));
    disp_q.push_back(mk(4'b1110, ~font(4'h5)));
    for (int k = 1; k <= 2; k++) begin
      wait_cyc(w + k);
      e = disp_q.pop_front();
      checks++;
      if (bus.an !== e.an || bus.seg !== e.seg) begin
        errors++;
        $display("FAIL capture_latency cyc %0d: an=%b seg=%h, want an=%b seg=%h", cyc, bus.an, bus.seg, e.an, e.seg);
      end
    end
  endtask

  task automatic test_skew;
    disp_t e;
    int w;
    bus.count_in = 4'h7;
    w = next_window(cyc + 8);
    wait_cyc(w - 4);
    bus.count_in = 4'hF;
    wait_cyc(w - 3);
    bus.count_in = 4'h8;
    disp_q.push_back(mk(4'b1110, ~font(4'h7)));
    disp_q.push_back(mk(4'b1110, ~font(4'h7)));
    disp_q.push_back(mk(4'b1110, ~font(4'h8)));
    disp_q.push_back(mk(4'b1110, ~font(4'h8)));
    for (int k = 0; k < 4; k++) begin
      wait_cyc(w + k);
      e = disp_q.pop_front();
      checks++;
      if (bus.an !== e.an || bus.seg !== e.seg) begin
        errors++;
        $display("FAIL skew_reject cyc %0d: an=%b seg=%h, want an=%b seg=%h", cyc, bus.an, bus.seg, e.an, e.seg);
      end
    end
    checks++;
    if (bus.wrap_bcd !== 8'h00) begin
      errors++;
      $display("FAIL skew_wrap: wrap=%h, want 00", bus.wrap_bcd);
    end
  endtask

  task automatic test_wraps;
    logic [7:0] exp;
    int n;
    bus.count_in = 4'h0;
    repeat (6) @(negedge clk);
    bus.count_in = 4'h5;
    repeat (6) @(negedge clk);
    bus.count_in = 4'h0;
    wrap_q.push_back(8'h00);
    repeat (6) @(negedge clk);
    exp = wrap_q.pop_front();
    checks++;
    if (bus.wrap_bcd !== exp) begin
      errors++;
      $display("FAIL non_f_jump: wrap=%h, want %h", bus.wrap_bcd, exp);
    end
    for (int k = 1; k <= 101; k++) begin
      n = k % 100;
      wrap_q.push_back({4'(n / 10), 4'(n % 10)});
      step_wrap();
      exp = wrap_q.pop_front();
      checks++;
      if (bus.wrap_bcd !== exp) begin
        errors++;
        $display("FAIL wrap_count %0d: wrap=%h, want %h", k, bus.wrap_bcd, exp);
      end
    end
  endtask

  task automatic test_clear_priority;
    disp_t e;
    logic [7:0] exp;
    int w, x;
    @(negedge clk);
    bus.clear_wraps = 1'b1;
    @(negedge clk);
    bus.clear_wraps = 1'b0;
    checks++;
    if (bus.wrap_bcd !== 8'h00) begin
      errors++;
      $display("FAIL clear_alone: wrap=%h, want 00", bus.wrap_bcd);
    end
    for (int k = 0; k < 42; k++) step_wrap();
    wrap_q.push_back(8'h42);
    exp = wrap_q.pop_front();
    checks++;
    if (bus.wrap_bcd !== exp) begin
      errors++;
      $display("FAIL wrap_42: wrap=%h, want %h", bus.wrap_bcd, exp);
    end
    w = next_window(cyc + 1);
    disp_q.push_back(mk(4'b1011, ~font(4'h2)));
    disp_q.push_back(mk(4'b0111, ~font(4'h4)));
    for (int k = 2; k <= 3; k++) begin
      wait_cyc(w + 4 * k + 1);
      e = disp_q.pop_front();
      checks++;
      if (bus.an !== e.an || bus.seg !== e.seg) begin
        errors++;
        $display("FAIL digit_42 idx %0d: an=%b seg=%h, want an=%b seg=%h", k, bus.an, bus.seg, e.an, e.seg);
      end
    end
    bus.count_in = 4'hF;
    repeat (6) @(negedge clk);
    bus.count_in = 4'h0;
    x = cyc;
    wait_cyc(x + 3);
    bus.clear_wraps = 1'b1;
    wait_cyc(x + 4);
    bus.clear_wraps = 1'b0;
    wrap_q.push_back(8'h00);
    repeat (3) @(negedge clk);
    exp = wrap_q.pop_front();
    checks++;
    if (bus.wrap_bcd !== exp) begin
      errors++;
      $display("FAIL clear_priority: wrap=%h, want %h", bus.wrap_bcd, exp);
    end
  endtask

  task automatic test_blanking;
    disp_t e;
    logic [7:0] exp;
    int w;
    for (int k = 0; k < 7; k++) step_wrap();
    wrap_q.push_back(8'h07);
    exp = wrap_q.pop_front();
    checks++;
    if (bus.wrap_bcd !== exp) begin
      errors++;
      $display("FAIL wrap_07: wrap=%h, want %h", bus.wrap_bcd, exp);
    end
    w = next_window(cyc + 1);
    disp_q.push_back(mk(4'b1110, ~font(4'h0)));
    disp_q.push_back(mk(4'b1101, 7'h7F));
    disp_q.push_back(mk(4'b1011, ~font(4'h7)));
    disp_q.push_back(mk(4'b0111, 7'h7F));
    for (int k = 0; k < 4; k++) begin
      wait_cyc(w + 4 * k + 2);
      e = disp_q.pop_front();
      checks++;
      if (bus.an !== e.an || bus.seg !== e.seg || bus.dp !== 1'b1) begin
        errors++;
        $display("FAIL blanking idx %0d: an=%b seg=%h dp=%b, want an=%b seg=%h dp=1",
                 k, bus.an, bus.seg, bus.dp, e.an, e.seg);
      end
    end
  endtask

  task automatic test_reset_midscan;
    disp_t e;
    wait_cyc(next_window(cyc + 1) + 1);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.wrap_bcd !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: an=%h seg=%h wrap=%h, want an=f seg=7f wrap=00", bus.an, bus.seg, bus.wrap_bcd);
    end
    @(negedge clk);
    rst = 1'b1;
    disp_q.push_back(mk(4'hF, 7'h7F));
    disp_q.push_back(mk(4'b1110, ~font(4'h0)));
    for (int k = 4; k <= 5; k++) begin
      wait_cyc(k);
      e = disp_q.pop_front();
      checks++;
      if (bus.an !== e.an || bus.seg !== e.seg) begin
        errors++;
        $display("FAIL rescan cyc %0d: an=%b seg=%h, want an=%b seg=%h", cyc, bus.an, bus.seg, e.an, e.seg);
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_capture();
    test_skew();
    test_wraps();
    test_clear_priority();
    test_blanking();
    test_reset_midscan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_count_display.md
Name: seg7_count_display

Overview:
- Downstream consumer of the 4-bit lab counter value; drives the board's 4-digit multiplexed seven-segment display.
- Samples the counter value into the system clock domain. The counter runs on a divided/derived clock.
- Digit 0 shows the value in hex. Digits 3:2 show a BCD count of counter wrap-arounds (F->0), 00..99. Digit 1 is always blank.
- Scans one digit at a time at a parameterised refresh rate.

Parameters:
- SCAN_DIV, 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz); legal range >= 2.
- SEG_ACTIVE_LOW, 1, 1 = segment lines are driven low to light.
- AN_ACTIVE_LOW, 1, 1 = anode enables are driven low to select.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- count_in  in  4  counter value from the upstream counter; asynchronous to clk.
- clear_wraps  in  1  synchronous single-cycle pulse; zeroes the wrap count.
- seg  out  7  segments {g,f,e,d,c,b,a}; seg[0]=a.
- dp  out  1  decimal point; always inactive.
- an  out  4  digit enables, one-hot active; an[0] = rightmost digit.
- wrap_bcd  out  8  {tens,ones} BCD wrap count, for debug/LEDs.

Behaviour:
- Reset (rst=0, async): sync regs, accepted value, wrap count, prescaler and digit index all go to 0. seg, an and dp are at inactive level (all-off; 7'h7F / 4'hF when active-low). wrap_bcd=8'h00.
- Input capture:
  - Three-flop chain s1<=count_in, s2<=s1, s3<=s2.
  - accepted<=s2 only when s2==s3, so a multi-bit skew glitch is never accepted.
  - A stable change sampled into s1 at edge E0 appears on accepted at edge E3.
- Wrap detection:
  - Increment only when accepted goes 4'hF -> 4'h0 in one update.
  - Any other change, including an upstream reset from a non-F value to 0, does not increment.
  - BCD increment: ones 9 -> 0 with carry into tens; 99 -> 00.
- Clear: clear_wraps=1 zeroes the wrap count on that edge. Clear has priority over a same-cycle increment; the result is 00.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. tick = (prescaler==SCAN_DIV-1), after which it wraps to 0.
  - On tick, the digit index advances 0->1->2->3->0.
  - seg, an and dp are registered and update on the edge after the index changes, so there is 1-cycle latency from index to pins.
  - While the first slot is counting after reset, the outputs stay all-off. The first digit lights one cycle after the first tick.
- Digit content:
  - Index 0 -> hex glyph of accepted.
  - Index 1 -> blank (all segments off, anode still asserted).
  - Index 2 -> ones digit of the wrap count.
  - Index 3 -> tens digit of the wrap count, blanked when tens==0 (leading-zero suppression).
- Hex glyphs:
  - Standard 7-seg font; digits 0-9 use the usual shapes, letters shown as A b C d E F.
  - Active-high patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - Inverted at the output when SEG_ACTIVE_LOW=1.
- Coherency: the glyph is taken from the value current at output-register time. Values may change mid-slot; no tearing across segments.
- Reset mid-scan: outputs go all-off immediately (async), and scanning restarts at index 0 after release.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry hex font constant (active-high);
  - the BLANK pattern;
  - the NUM_DIGITS=4 constant;
  - the digit-index width.
- Natural sub-module: hex_to_seg7 (combinational 4-bit -> 7-bit font lookup with a blank input), instantiated once on the muxed digit.
- Synchroniser, wrap counter and scanner stay in the top block.

Test Plan:
- Reset and first scan (SCAN_DIV=4): hold rst=0, then release. Expect an=4'hF and seg=7'h7F for 4 cycles, then an=4'b1110 with seg=~7'h3F (glyph 0).
- Input capture: count_in 0 -> 5 (stable). accepted=5 at E3. Next index-0 slot shows seg=~7'h6D.
- Skew rejection: count_in 7 -> 8 via a one-cycle 4'hF glitch. The F is never accepted, the wrap count stays 00, and accepted ends at 8.
- Wrap counting: step count_in 0..F then 0, 101 times. Expect wrap_bcd 00 -> 09 -> 10 ... 99 -> 00 after wrap 100, then 01 after wrap 101. A non-F -> 0 jump does not increment.
- Clear priority: drive clear_wraps=1 on the same edge as an F->0 acceptance with wrap=42. Expect wrap_bcd=00.
- Blanking: with wrap=07, the index-3 slot gives an=4'b0111 and seg=7'h7F. The index-1 slot gives an=4'b1101 and seg=7'h7F. The index-2 slot shows glyph 7 (~7'h07).
